// File: rtl/pulse_period_meter.sv
// Pulse period meter: counts clk_in cycles between rising edges of pulse_in,
// with a saturating counter and a programmable lost-pulse timeout.
module pulse_period_meter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_in,
    input  logic             RST,
    input  logic             pulse_in,
    input  logic [WIDTH-1:0] timeout_limit,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             overflow,
    output logic             timeout_flag,
    output logic             measuring
);

    typedef enum logic [0:0] {StIdle, StMeasure} state_e;

    localparam logic [WIDTH:0] CountMax = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0] CountOne = {{WIDTH{1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic             p_q;
    logic [WIDTH-1:0] count_q, count_d;
    logic             sat_q, sat_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             to_q, to_d;

    logic             pulse_edge;
    logic [WIDTH:0]   count_inc;
    logic             timeout_hit;

    assign pulse_edge  = pulse_in & ~p_q;
    // One extra bit so the all-ones compare and the timeout compare never wrap.
    assign count_inc   = {1'b0, count_q} + CountOne;
    assign timeout_hit = (timeout_limit != '0) && (count_inc >= {1'b0, timeout_limit});

    // State register
    always_ff @(posedge clk_in) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an edge always takes priority over the timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (pulse_edge) begin
                    state_d = StMeasure;
                end
            end
            StMeasure: begin
                if (!pulse_edge && timeout_hit) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state
    always_comb begin
        count_d  = count_q;
        sat_d    = sat_q;
        period_d = period_q;
        valid_d  = 1'b0;
        ovf_d    = 1'b0;
        to_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pulse_edge) begin
                    count_d = '0;
                    sat_d   = 1'b0;
                end
            end
            StMeasure: begin
                if (pulse_edge) begin
                    period_d = sat_q ? {WIDTH{1'b1}} : count_inc[WIDTH-1:0];
                    valid_d  = 1'b1;
                    ovf_d    = sat_q;
                    count_d  = '0;
                    sat_d    = 1'b0;
                end else if (timeout_hit) begin
                    to_d    = 1'b1;
                    count_d = '0;
                end else if (count_inc == CountMax) begin
                    sat_d = 1'b1;
                end else begin
                    count_d = count_inc[WIDTH-1:0];
                end
            end
            default: begin
                count_d = '0;
                sat_d   = 1'b0;
            end
        endcase
    end

    // Datapath registers; p_q resets high so a level held through reset is not an edge
    always_ff @(posedge clk_in) begin
        if (RST) begin
            p_q      <= 1'b1;
            count_q  <= '0;
            sat_q    <= 1'b0;
            period_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            p_q      <= pulse_in;
            count_q  <= count_d;
            sat_q    <= sat_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            to_q     <= to_d;
        end
    end

    // Outputs
    always_comb begin
        period       = period_q;
        period_valid = valid_q;
        overflow     = ovf_q;
        timeout_flag = to_q;
        measuring    = (state_q == StMeasure);
    end

endmodule

// File: doc/pulse_period_meter.md
# pulse_period_meter

Measures the interval, in `clk_in` cycles, between consecutive rising edges of a pulse train and reports it as an unsigned count with a one-cycle valid strobe. It is the inverse of the display tick divider: a tick produced every N+1 cycles is read back as period N+1. It sits between a tick or pulse source (divider output, external sensor, button line) and the seven-segment formatting logic. A programmable timeout detects a lost or stopped pulse train.

## Interface
- `WIDTH`, 32, width of the cycle counter, `period` and `timeout_limit`.
- `clk_in`  input  1  system clock; all logic on rising edge.
- `RST`  input  1  synchronous, active-high reset.
- `pulse_in`  input  1  pulse train, already synchronous to `clk_in`; only rising edges are meaningful.
- `timeout_limit`  input  WIDTH  maximum accepted period in cycles; 0 disables timeout; sampled every cycle.
- `period`  output  WIDTH  last measured period; holds between updates.
- `period_valid`  output  1  one-cycle strobe, `period` updated this cycle.
- `overflow`  output  1  one-cycle strobe coincident with `period_valid`; counter saturated, `period` = all ones.
- `timeout_flag`  output  1  one-cycle strobe, no edge within `timeout_limit` cycles; measurement abandoned.
- `measuring`  output  1  high while in MEASURE state.

## Operation
- Edge detect: `p_q` registers `pulse_in`; `edge = pulse_in & ~p_q`. `p_q` resets to 1, so a level held high through reset produces no edge.
- Internal `count` (WIDTH bits) holds cycles elapsed since the last edge, minus one. A saturation flag `sat` is also kept.
- States:
  - IDLE: on `edge`, set `count <= 0` and `sat <= 0`, then go to MEASURE. No strobe is issued.
  - MEASURE, `edge`: `period <= sat ? all-ones : count+1`, `period_valid <= 1`, `overflow <= sat`, `count <= 0`, `sat <= 0`. Stay in MEASURE.
  - MEASURE, no edge, `timeout_limit != 0` and `count+1 >= timeout_limit`: `timeout_flag <= 1`, `count <= 0`, go to IDLE. `period` is unchanged.
  - MEASURE, no edge, otherwise: if `count+1` equals all ones, set `sat <= 1` and hold `count`. Otherwise `count <= count+1`.
- Edge and timeout condition in the same cycle: the edge wins. A period equal to `timeout_limit` is reported; a period greater than it times out.
- A change to `timeout_limit` mid-measurement takes effect immediately. Because the compare is `>=`, lowering the limit below the elapsed count fires the timeout next cycle.
- `count+1` is computed at WIDTH+1 bits, so there is no wrap.
- Reset: `period = 0`, `period_valid = 0`, `overflow = 0`, `timeout_flag = 0`, `measuring = 0`, state IDLE, `count = 0`, `sat = 0`, `p_q = 1`. Reset mid-measurement discards the partial count. The first edge after reset only arms the meter.

## Timing
- With edges sampled at cycles t and t+P, `period_valid` and `period = P` are registered at the edge of cycle t+P and are visible from cycle t+P+1. Latency is one cycle after the closing edge.
- The minimum measurable period is 2 (alternating 1,0 input). A continuously high input produces no further edges.
- With no edge after cycle t, `timeout_flag` is visible one cycle after the clock edge at t+L, where L = `timeout_limit`.
- `period_valid`, `overflow` and `timeout_flag` are single-cycle pulses, and `period_valid` and `timeout_flag` are never high together.
- `measuring` goes high one cycle after the arming edge. It goes low in the same cycle `timeout_flag` goes high.

## Test plan
- Drive `pulse_in` with one-cycle ticks every 10 cycles (divider setting 9), `timeout_limit = 0`. First tick: no strobe. Second and later ticks: `period_valid` with `period = 10`, repeating every 10 cycles.
- Set `timeout_limit = 50`.
  - Ticks spaced 50: `period = 50`.
  - Then a 51-cycle gap: `timeout_flag` pulses 50 cycles after the last edge and `measuring` drops. The next tick gives no strobe; the tick after it gives the correct period.
- Hold `pulse_in` high through reset and for 100 cycles after, then drop it. Then give ticks 7 apart. There is no edge from the held level; the first tick arms, and the second gives `period = 7`.
- Alternate `pulse_in` 1,0,1,0. `period_valid` fires every 2 cycles with `period = 2`.
- Assert `RST` 5 cycles into a 20-cycle gap. All outputs return to 0 on the next cycle. The next tick arms with no strobe; the following tick reports the true spacing.
- `WIDTH = 8`, `timeout_limit = 0`.
  - Gap of 300: `period = 255` with `overflow = 1`.
  - Next gap of 12: `period = 12`, `overflow = 0`.
